perceptron_trainer: RTL and testbench

Training sequencer for the perceptron branch predictor's weight table (`ptable`). It accepts resolved-branch update requests from commit, decides whether each needs training (mispredict or low-confidence output), and runs a read-modify-write on the table's second port (r2). The write applies a saturating ±1 adjustment to each of the HIST_LEN+1 weights. It owns the table's write port exclusively; the fetch-side predictor keeps port r1.

---
 rtl/perceptron_trainer.sv | 159 +++++++++++++++
 tb/tb_perceptron_trainer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_trainer.sv
// perceptron_trainer: serialises resolved-branch updates into read-modify-write
// passes over the perceptron weight table's second port. Each trained row gets a
// saturating +/-1 step per weight; confident correct predictions are dropped.
// Optional build macro PERCEPTRON_TRAINER_STATS_EN adds train_cnt/skip_cnt outputs.
module perceptron_trainer #(
  parameter int W_BITS     = 8,
  parameter int HIST_LEN   = 12,
  parameter int IDX_BITS   = 4,
  parameter int Y_BITS     = 12,
  parameter int THETA      = 37,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             upd_valid,
  output logic                             upd_ready,
  input  logic [IDX_BITS-1:0]              upd_index,
  input  logic [HIST_LEN-1:0]              upd_hist,
  input  logic                             upd_taken,
  input  logic                             upd_pred,
  input  logic [Y_BITS-1:0]                upd_y,
  output logic [IDX_BITS-1:0]              pt_index,
  input  logic [HIST_LEN:0][W_BITS-1:0]    pt_rdata,
  output logic [HIST_LEN:0][W_BITS-1:0]    pt_wdata,
  output logic                             pt_wr_en,
  output logic                             busy
`ifdef PERCEPTRON_TRAINER_STATS_EN
  ,
  output logic [15:0]                      train_cnt,
  output logic [15:0]                      skip_cnt
`endif
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] CALC  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam logic [W_BITS-1:0] W_MAX = {1'b0, {(W_BITS-1){1'b1}}};
  localparam logic [W_BITS-1:0] W_MIN = {1'b1, {(W_BITS-1){1'b0}}};
  localparam logic [Y_BITS:0]   THETA_EXT = (Y_BITS+1)'(THETA);

  // Request buffer storage and pointers (extra MSB distinguishes full from empty)
  logic [IDX_BITS-1:0] fifo_index [FIFO_DEPTH];
  logic [HIST_LEN-1:0] fifo_hist  [FIFO_DEPTH];
  logic                fifo_taken [FIFO_DEPTH];
  logic                fifo_pred  [FIFO_DEPTH];
  logic [Y_BITS-1:0]   fifo_y     [FIFO_DEPTH];
  logic [PTR_BITS:0]   wr_ptr_reg;
  logic [PTR_BITS:0]   rd_ptr_reg;

  logic [1:0]                   state_reg;
  logic [HIST_LEN-1:0]          hist_reg;
  logic                         taken_reg;
  logic [HIST_LEN:0][W_BITS-1:0] w_reg;
  logic [HIST_LEN:0][W_BITS-1:0] w_next;
  logic [HIST_LEN:0]            step_up;

  logic empty, full, push, pop, head_train;
  logic [Y_BITS:0] y_ext, y_mag;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PTR_BITS] != rd_ptr_reg[PTR_BITS]) &&
                 (wr_ptr_reg[PTR_BITS-1:0] == rd_ptr_reg[PTR_BITS-1:0]);
  // Gating with rst_n keeps ready low while reset is held.
  assign upd_ready = rst_n && !full;
  assign push      = upd_valid && upd_ready;
  assign pop       = (state_reg == IDLE) && !empty;
  assign busy      = (state_reg != IDLE) || !empty;
  assign pt_wr_en  = (state_reg == WRITE);

  // Magnitude in Y_BITS+1 bits so the most negative y is not mistaken for small.
  assign y_ext = {fifo_y[rd_ptr_reg[PTR_BITS-1:0]][Y_BITS-1], fifo_y[rd_ptr_reg[PTR_BITS-1:0]]};
  assign y_mag = y_ext[Y_BITS] ? (~y_ext + (Y_BITS+1)'(1)) : y_ext;
  assign head_train = (fifo_taken[rd_ptr_reg[PTR_BITS-1:0]] != fifo_pred[rd_ptr_reg[PTR_BITS-1:0]]) ||
                      (y_mag <= THETA_EXT);

  // Per-weight direction and saturating step; weight 0 (bias) always follows taken.
  for (genvar gi = 0; gi <= HIST_LEN; gi++) begin : g_weight
    if (gi == 0) begin : g_bias
      assign step_up[gi] = taken_reg;
    end else begin : g_hist
      assign step_up[gi] = ~(hist_reg[gi-1] ^ taken_reg);
    end
    assign w_next[gi] = step_up[gi]
                      ? ((w_reg[gi] == W_MAX) ? w_reg[gi] : w_reg[gi] + W_BITS'(1))
                      : ((w_reg[gi] == W_MIN) ? w_reg[gi] : w_reg[gi] - W_BITS'(1));
  end

  // Buffer payload write; no reset needed since push is blocked during reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_index[wr_ptr_reg[PTR_BITS-1:0]] <= upd_index;
      fifo_hist[wr_ptr_reg[PTR_BITS-1:0]]  <= upd_hist;
      fifo_taken[wr_ptr_reg[PTR_BITS-1:0]] <= upd_taken;
      fifo_pred[wr_ptr_reg[PTR_BITS-1:0]]  <= upd_pred;
      fifo_y[wr_ptr_reg[PTR_BITS-1:0]]     <= upd_y;
    end
  end

  // Buffer pointer advance on push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + (PTR_BITS+1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (PTR_BITS+1)'(1);
    end
  end

  // Sequencer: pop/decide, read row, compute saturated row, write row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pt_index  <= '0;
      hist_reg  <= '0;
      taken_reg <= 1'b0;
      w_reg     <= '0;
      pt_wdata  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pop && head_train) begin
            pt_index  <= fifo_index[rd_ptr_reg[PTR_BITS-1:0]];
            hist_reg  <= fifo_hist[rd_ptr_reg[PTR_BITS-1:0]];
            taken_reg <= fifo_taken[rd_ptr_reg[PTR_BITS-1:0]];
            state_reg <= READ;
          end
        end
        READ: begin
          w_reg     <= pt_rdata;
          state_reg <= CALC;
        end
        CALC: begin
          pt_wdata  <= w_next;
          state_reg <= WRITE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef PERCEPTRON_TRAINER_STATS_EN
  // Saturating counters of trained and discarded pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      train_cnt <= '0;
      skip_cnt  <= '0;
    end else if (pop) begin
      if (head_train && train_cnt != 16'hFFFF) train_cnt <= train_cnt + 16'd1;
      if (!head_train && skip_cnt != 16'hFFFF) skip_cnt <= skip_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer with a behavioural weight-table model.
module tb_perceptron_trainer;

  typedef logic [12:0][7:0] row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic upd_valid = 1'b0;
  logic upd_ready;
  logic [3:0]  upd_index = '0;
  logic [11:0] upd_hist = '0;
  logic upd_taken = 1'b0;
  logic upd_pred = 1'b0;
  logic [11:0] upd_y = '0;
  logic [3:0]  pt_index;
  row_t pt_rdata;
  row_t pt_wdata;
  logic pt_wr_en;
  logic busy;
`ifdef PERCEPTRON_TRAINER_STATS_EN
  logic [15:0] train_cnt, skip_cnt;
`endif

  row_t mem [16];
  int cyc = 0;
  int wr_cnt = 0;
  int last_wr_cyc = -1;
  int push_cyc = 0;
  int total = 0;
  int bad = 0;
  int w0;

  perceptron_trainer dut (
    .clk(clk), .rst_n(rst_n),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_index(upd_index), .upd_hist(upd_hist),
    .upd_taken(upd_taken), .upd_pred(upd_pred), .upd_y(upd_y),
    .pt_index(pt_index), .pt_rdata(pt_rdata), .pt_wdata(pt_wdata),
    .pt_wr_en(pt_wr_en), .busy(busy)
`ifdef PERCEPTRON_TRAINER_STATS_EN
    , .train_cnt(train_cnt), .skip_cnt(skip_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign pt_rdata = mem[pt_index];

  // Table model: write port commits at the rising edge; also logs pulses.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pt_wr_en) begin
      mem[pt_index] <= pt_wdata;
      wr_cnt <= wr_cnt + 1;
      last_wr_cyc <= cyc;
    end
  end

  function automatic row_t fill(input logic [7:0] b);
    return {13{b}};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] idx, input logic [11:0] h, input logic tk,
                      input logic pr, input logic [11:0] y);
    int n = 0;
    @(negedge clk);
    while (!upd_ready && n < 50) begin
      upd_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    if (!upd_ready) begin
      total++; bad++;
      $error("FAIL push_timeout observed=ready_low expected=ready_high");
    end
    upd_valid = 1'b1; upd_index = idx; upd_hist = h;
    upd_taken = tk; upd_pred = pr; upd_y = y;
    push_cyc = cyc;
    @(posedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    upd_valid = 1'b0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++; bad++;
      $error("FAIL idle_timeout observed=busy expected=idle");
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset state
    #1;
    check("rst_ready_low", 128'(upd_ready), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_wr_en", 128'(pt_wr_en), 128'(0));
    check("rst_index", 128'(pt_index), 128'(0));
    check("rst_wdata", 128'(pt_wdata), 128'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready_high", 128'(upd_ready), 128'(1));
    check("rst_busy_after", 128'(busy), 128'(0));

    // Mispredict on row 3: every weight steps 0 -> 1
    w0 = wr_cnt;
    push(4'd3, 12'hFFF, 1'b1, 1'b0, 12'hFFB);  // y = -5
    wait_idle();
    check("mis_row3", 128'(mem[3]), 128'(fill(8'h01)));
    check("mis_pulses", 128'(wr_cnt - w0), 128'(1));
    check("mis_latency", 128'(last_wr_cyc), 128'(push_cyc + 4));
    check("mis_index", 128'(pt_index), 128'(3));
    check("mis_wdata", 128'(pt_wdata), 128'(fill(8'h01)));

    // Confidence threshold on row 4
    w0 = wr_cnt;
    push(4'd4, 12'hFFF, 1'b1, 1'b1, 12'h064);  // y = 100, skip
    wait_idle();
    check("conf_y100_pulses", 128'(wr_cnt - w0), 128'(0));
    push(4'd4, 12'hFFF, 1'b1, 1'b1, 12'h025);  // y = 37, trains
    wait_idle();
    check("conf_y37_pulses", 128'(wr_cnt - w0), 128'(1));
    check("conf_y37_row", 128'(mem[4]), 128'(fill(8'h01)));
    push(4'd4, 12'hFFF, 1'b1, 1'b1, 12'hFDA);  // y = -38, skip
    push(4'd4, 12'hFFF, 1'b1, 1'b1, 12'h800);  // y = -2048, skip
    wait_idle();
    check("conf_big_pulses", 128'(wr_cnt - w0), 128'(1));
    push(4'd4, 12'hFFF, 1'b1, 1'b1, 12'hFDB);  // y = -37, trains
    wait_idle();
    check("conf_ym37_row", 128'(mem[4]), 128'(fill(8'h02)));

    // Saturation
    mem[6] = fill(8'h7F);
    mem[7] = fill(8'h80);
    mem[8] = fill(8'h7F);
    push(4'd6, 12'hFFF, 1'b1, 1'b0, 12'h000);
    wait_idle();
    check("sat_pos", 128'(mem[6]), 128'(fill(8'h7F)));
    push(4'd7, 12'hFFF, 1'b0, 1'b1, 12'h000);
    wait_idle();
    check("sat_neg", 128'(mem[7]), 128'(fill(8'h80)));
    push(4'd8, 12'h000, 1'b1, 1'b0, 12'h000);
    wait_idle();
    check("sat_mixed", 128'(mem[8]), 128'({{12{8'h7E}}, 8'h7F}));

    // Backpressure: three back-to-back trained requests to row 5
    w0 = wr_cnt;
    push(4'd5, 12'hFFF, 1'b1, 1'b0, 12'h000);
    push(4'd5, 12'hFFF, 1'b1, 1'b0, 12'h000);
    push(4'd5, 12'hFFF, 1'b1, 1'b0, 12'h000);
    @(negedge clk);
    upd_valid = 1'b0;
    check("bp_ready_low", 128'(upd_ready), 128'(0));
    wait_idle();
    check("bp_row5", 128'(mem[5]), 128'(fill(8'h03)));
    check("bp_pulses", 128'(wr_cnt - w0), 128'(3));
    check("bp_busy_fall", 128'(last_wr_cyc), 128'(cyc - 1));

    // Reset while in CALC on row 9
    w0 = wr_cnt;
    push(4'd9, 12'hFFF, 1'b1, 1'b0, 12'hFFB);
    @(negedge clk);
    upd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_wr_en", 128'(pt_wr_en), 128'(0));
    check("mid_rst_ready", 128'(upd_ready), 128'(0));
    check("mid_rst_wdata", 128'(pt_wdata), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_rst_row9", 128'(mem[9]), 128'(fill(8'h00)));
    check("mid_rst_pulses", 128'(wr_cnt - w0), 128'(0));
    check("mid_rst_ready_after", 128'(upd_ready), 128'(1));
    check("mid_rst_busy_after", 128'(busy), 128'(0));
    check("mid_rst_index", 128'(pt_index), 128'(0));

`ifdef PERCEPTRON_TRAINER_STATS_EN
    // Counters restart from the reset above: 2 trained, 3 skipped
    push(4'd10, 12'hFFF, 1'b1, 1'b0, 12'h000);
    push(4'd10, 12'hFFF, 1'b1, 1'b1, 12'h064);
    push(4'd10, 12'hFFF, 1'b0, 1'b1, 12'h000);
    push(4'd10, 12'hFFF, 1'b0, 1'b0, 12'h800);
    push(4'd10, 12'hFFF, 1'b1, 1'b1, 12'hFDA);
    wait_idle();
    check("stats_train", 128'(train_cnt), 128'(2));
    check("stats_skip", 128'(skip_cnt), 128'(3));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
